scan_test_painter: RTL and testbench

- Parametrised, multi-mode successor to the LED panel address-test painter.
- Generates per-pixel RGB test patterns for the panel driver: static address bits, a marching column, a marching row, and a scaling checkerboard.
- Advances patterns from the driver's frame counter, with automatic mode cycling.
- Sits between the scan/timing logic, which supplies frame/subframe/x/y, and the panel shifter. Output is registered.

---
 rtl/scan_test_painter.sv | 148 ++++++++++++++
 tb/tb_scan_test_painter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/scan_test_painter.sv
// LED panel test-pattern painter: address bits, marching column/row and a scaling
// checkerboard, stepped by frame ticks with optional automatic mode cycling.
//
// mode  | meaning
// 0     | static address bits {border, y pow2, x pow2}
// 1     | marching column (green) over border (blue)
// 2     | marching row (red) over border (blue)
// 3     | checkerboard, square size 2**cursor[1:0]
module scan_test_painter #(
  parameter int X_BITS      = 6,
  parameter int Y_BITS      = 6,
  parameter int FRAME_BITS  = 13,
  parameter int STEP_FRAMES = 4,
  parameter int MODE_FRAMES = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [7:0]            subframe,
  input  logic [X_BITS-1:0]     x,
  input  logic [Y_BITS-1:0]     y,
  input  logic                  auto_en,
  input  logic                  mode_next,
  output logic [2:0]            rgb,
  output logic [1:0]            mode
);

  localparam int C_BITS = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
  localparam int S_BITS = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int D_BITS = (MODE_FRAMES > 1) ? $clog2(MODE_FRAMES) : 1;

  localparam logic [S_BITS-1:0] STEP_LAST  = S_BITS'(STEP_FRAMES - 1);
  localparam logic [D_BITS-1:0] DWELL_LAST = D_BITS'(MODE_FRAMES - 1);
  localparam logic [C_BITS-1:0] X_LAST     = C_BITS'((1 << X_BITS) - 1);
  localparam logic [C_BITS-1:0] Y_LAST     = C_BITS'((1 << Y_BITS) - 1);
  localparam logic [C_BITS-1:0] CHK_LAST   = C_BITS'(3);

  localparam logic [1:0] M_ADDR  = 2'd0;
  localparam logic [1:0] M_COL   = 2'd1;
  localparam logic [1:0] M_ROW   = 2'd2;
  localparam logic [1:0] M_CHECK = 2'd3;

  logic [1:0]            r_mode;
  logic [C_BITS-1:0]     r_cursor;
  logic [S_BITS-1:0]     r_step_cnt;
  logic [D_BITS-1:0]     r_dwell_cnt;
  logic [FRAME_BITS-1:0] r_prev_frame;
  logic [2:0]            r_rgb;

  logic [1:0]        w_mode_nxt;
  logic [C_BITS-1:0] w_cursor_nxt;
  logic [C_BITS-1:0] w_cursor_wrap;
  logic [S_BITS-1:0] w_step_nxt;
  logic [D_BITS-1:0] w_dwell_nxt;
  logic              w_tick;
  logic              w_step_done;
  logic              w_dwell_done;
  logic              w_adv;
  logic [2:0]        w_pix;
  logic              w_border;
  logic              w_xs;
  logic              w_ys;
  logic [1:0]        w_k;
  logic              w_chk;
  logic              w_unused;

  // subframe only exists so this painter drops into the common painter socket
  assign w_unused = ^subframe;

  assign w_tick       = (frame != r_prev_frame);
  assign w_step_done  = (r_step_cnt == STEP_LAST);
  assign w_dwell_done = (r_dwell_cnt == DWELL_LAST);
  assign w_adv        = mode_next | (auto_en & w_tick & w_dwell_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode       <= M_ADDR;
      r_cursor     <= '0;
      r_step_cnt   <= '0;
      r_dwell_cnt  <= '0;
      r_prev_frame <= frame;
      r_rgb        <= '0;
    end else begin
      r_mode       <= w_mode_nxt;
      r_cursor     <= w_cursor_nxt;
      r_step_cnt   <= w_step_nxt;
      r_dwell_cnt  <= w_dwell_nxt;
      r_prev_frame <= frame;
      r_rgb        <= w_pix;
    end
  end

  always_comb begin
    w_cursor_wrap = '0;
    case (r_mode)
      M_COL:   w_cursor_wrap = (r_cursor == X_LAST)   ? '0 : r_cursor + C_BITS'(1);
      M_ROW:   w_cursor_wrap = (r_cursor == Y_LAST)   ? '0 : r_cursor + C_BITS'(1);
      M_CHECK: w_cursor_wrap = (r_cursor == CHK_LAST) ? '0 : r_cursor + C_BITS'(1);
      default: w_cursor_wrap = '0;
    endcase
  end

  // A mode advance wins over a same-cycle cursor step and restarts every timer.
  always_comb begin
    w_mode_nxt   = r_mode;
    w_cursor_nxt = r_cursor;
    w_step_nxt   = r_step_cnt;
    w_dwell_nxt  = r_dwell_cnt;
    if (w_tick) begin
      if (w_step_done) begin
        w_step_nxt   = '0;
        w_cursor_nxt = w_cursor_wrap;
      end else begin
        w_step_nxt = r_step_cnt + S_BITS'(1);
      end
      if (auto_en && !w_dwell_done) begin
        w_dwell_nxt = r_dwell_cnt + D_BITS'(1);
      end
    end
    if (w_adv) begin
      w_mode_nxt   = r_mode + 2'd1;
      w_cursor_nxt = '0;
      w_step_nxt   = '0;
      w_dwell_nxt  = '0;
    end
  end

  assign w_border = (x == '0) | (x == '1) | (y == '0) | (y == '1);
  assign w_xs     = (x != '0) && ((x & (x - X_BITS'(1))) == '0);
  assign w_ys     = (y != '0) && ((y & (y - Y_BITS'(1))) == '0);
  assign w_k      = r_cursor[1:0];
  assign w_chk    = x[w_k] ^ y[w_k];

  always_comb begin
    w_pix = '0;
    case (r_mode)
      M_ADDR:  w_pix = {w_border, w_ys, w_xs};
      M_COL:   w_pix = {w_border, (x == r_cursor[X_BITS-1:0]), 1'b0};
      M_ROW:   w_pix = {w_border, 1'b0, (y == r_cursor[Y_BITS-1:0])};
      M_CHECK: w_pix = {w_chk, w_chk, w_chk};
      default: w_pix = '0;
    endcase
  end

  assign rgb  = r_rgb;
  assign mode = r_mode;

endmodule

// File: tb/tb_scan_test_painter.sv
// Directed bench for scan_test_painter: one task per scenario, inline checks on rgb/mode.
module tb_scan_test_painter;

  logic        clk;
  logic        reset;
  logic [12:0] frame;
  logic [7:0]  subframe;
  logic [5:0]  x;
  logic [5:0]  y;
  logic        auto_en;
  logic        mode_next;
  logic [2:0]  rgb;
  logic [1:0]  mode;

  int n_pass  = 0;
  int n_total = 0;

  scan_test_painter #(
    .X_BITS(6), .Y_BITS(6), .FRAME_BITS(13), .STEP_FRAMES(4), .MODE_FRAMES(8)
  ) dut (
    .clk(clk), .reset(reset), .frame(frame), .subframe(subframe), .x(x), .y(y),
    .auto_en(auto_en), .mode_next(mode_next), .rgb(rgb), .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame = frame + 13'd1;
      step();
    end
  endtask

  task automatic pix(input logic [5:0] px, input logic [5:0] py);
    x = px;
    y = py;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x = 6'd0; y = 6'd0;
    step();
    n_total++; if (rgb !== 3'b000) $display("FAIL reset_rgb got=%b exp=000", rgb); else n_pass++;
    n_total++; if (mode !== 2'd0) $display("FAIL reset_mode got=%0d exp=0", mode); else n_pass++;
    reset = 1'b0;
    pix(6'd0, 6'd5);
    n_total++; if (rgb !== 3'b100) $display("FAIL m0_x0y5 got=%b exp=100", rgb); else n_pass++;
    pix(6'd16, 6'd3);
    n_total++; if (rgb !== 3'b001) $display("FAIL m0_x16y3 got=%b exp=001", rgb); else n_pass++;
    pix(6'd5, 6'd63);
    n_total++; if (rgb !== 3'b100) $display("FAIL m0_x5y63 got=%b exp=100", rgb); else n_pass++;
    pix(6'd4, 6'd8);
    n_total++; if (rgb !== 3'b011) $display("FAIL m0_x4y8 got=%b exp=011", rgb); else n_pass++;
  endtask

  task automatic test_march_col();
    mode_next = 1'b1;
    step();
    mode_next = 1'b0;
    n_total++; if (mode !== 2'd1) $display("FAIL col_mode got=%0d exp=1", mode); else n_pass++;
    ticks(8);
    pix(6'd2, 6'd10);
    n_total++; if (rgb !== 3'b010) $display("FAIL col_c2_x2 got=%b exp=010", rgb); else n_pass++;
    pix(6'd3, 6'd10);
    n_total++; if (rgb !== 3'b000) $display("FAIL col_c2_x3 got=%b exp=000", rgb); else n_pass++;
    ticks(244);
    pix(6'd63, 6'd10);
    n_total++; if (rgb !== 3'b110) $display("FAIL col_c63_x63 got=%b exp=110", rgb); else n_pass++;
    pix(6'd62, 6'd10);
    n_total++; if (rgb !== 3'b000) $display("FAIL col_c63_x62 got=%b exp=000", rgb); else n_pass++;
    ticks(4);
    pix(6'd0, 6'd10);
    n_total++; if (rgb !== 3'b110) $display("FAIL col_wrap_x0 got=%b exp=110", rgb); else n_pass++;
    pix(6'd63, 6'd10);
    n_total++; if (rgb !== 3'b100) $display("FAIL col_wrap_x63 got=%b exp=100", rgb); else n_pass++;
  endtask

  task automatic test_auto();
    do_reset();
    auto_en = 1'b1;
    ticks(7);
    n_total++; if (mode !== 2'd0) $display("FAIL auto_t7 got=%0d exp=0", mode); else n_pass++;
    ticks(1);
    n_total++; if (mode !== 2'd1) $display("FAIL auto_t8 got=%0d exp=1", mode); else n_pass++;
    ticks(3);
    pix(6'd1, 6'd10);
    n_total++; if (rgb !== 3'b000) $display("FAIL auto_cur0 got=%b exp=000", rgb); else n_pass++;
    ticks(1);
    pix(6'd1, 6'd10);
    n_total++; if (rgb !== 3'b010) $display("FAIL auto_cur1 got=%b exp=010", rgb); else n_pass++;
    ticks(3);
    n_total++; if (mode !== 2'd1) $display("FAIL auto_t15 got=%0d exp=1", mode); else n_pass++;
    ticks(1);
    n_total++; if (mode !== 2'd2) $display("FAIL auto_t16 got=%0d exp=2", mode); else n_pass++;
    ticks(8);
    n_total++; if (mode !== 2'd3) $display("FAIL auto_t24 got=%0d exp=3", mode); else n_pass++;
    ticks(8);
    n_total++; if (mode !== 2'd0) $display("FAIL auto_t32 got=%0d exp=0", mode); else n_pass++;
  endtask

  task automatic test_coincident();
    ticks(7);
    frame = frame + 13'd1;
    mode_next = 1'b1;
    step();
    mode_next = 1'b0;
    n_total++; if (mode !== 2'd1) $display("FAIL coinc_mode got=%0d exp=1", mode); else n_pass++;
    ticks(1);
    n_total++; if (mode !== 2'd1) $display("FAIL coinc_dwell got=%0d exp=1", mode); else n_pass++;
    auto_en = 1'b0;
  endtask

  task automatic test_checker();
    mode_next = 1'b1;
    step();
    step();
    mode_next = 1'b0;
    n_total++; if (mode !== 2'd3) $display("FAIL chk_mode got=%0d exp=3", mode); else n_pass++;
    ticks(8);
    pix(6'd4, 6'd0);
    n_total++; if (rgb !== 3'b111) $display("FAIL chk_k2_x4y0 got=%b exp=111", rgb); else n_pass++;
    pix(6'd4, 6'd4);
    n_total++; if (rgb !== 3'b000) $display("FAIL chk_k2_x4y4 got=%b exp=000", rgb); else n_pass++;
    ticks(4);
    pix(6'd8, 6'd0);
    n_total++; if (rgb !== 3'b111) $display("FAIL chk_k3_x8y0 got=%b exp=111", rgb); else n_pass++;
    pix(6'd4, 6'd0);
    n_total++; if (rgb !== 3'b000) $display("FAIL chk_k3_x4y0 got=%b exp=000", rgb); else n_pass++;
    ticks(4);
    pix(6'd1, 6'd0);
    n_total++; if (rgb !== 3'b111) $display("FAIL chk_k0_x1y0 got=%b exp=111", rgb); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    frame = 13'd31;
    step();
    mode_next = 1'b1;
    step();
    step();
    mode_next = 1'b0;
    ticks(69);
    n_total++; if (mode !== 2'd2) $display("FAIL mid_mode got=%0d exp=2", mode); else n_pass++;
    pix(6'd5, 6'd17);
    n_total++; if (rgb !== 3'b001) $display("FAIL mid_row17 got=%b exp=001", rgb); else n_pass++;
    reset = 1'b1;
    mode_next = 1'b1;
    auto_en = 1'b1;
    step();
    n_total++; if (mode !== 2'd0) $display("FAIL mid_rst_mode got=%0d exp=0", mode); else n_pass++;
    n_total++; if (rgb !== 3'b000) $display("FAIL mid_rst_rgb got=%b exp=000", rgb); else n_pass++;
    reset = 1'b0;
    mode_next = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_total++; if (mode !== 2'd0) $display("FAIL mid_hold got=%0d exp=0", mode); else n_pass++;
    ticks(6);
    frame = 13'h1fff;
    step();
    n_total++; if (mode !== 2'd0) $display("FAIL wrap_t7 got=%0d exp=0", mode); else n_pass++;
    frame = 13'd0;
    step();
    n_total++; if (mode !== 2'd1) $display("FAIL wrap_t8 got=%0d exp=1", mode); else n_pass++;
    auto_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame = 13'd0;
    subframe = 8'd0;
    x = 6'd0;
    y = 6'd0;
    auto_en = 1'b0;
    mode_next = 1'b0;
    step();
    test_reset();
    test_march_col();
    test_auto();
    test_coincident();
    test_checker();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
